// File: rtl/spi_shift_ctrl_if.sv
// Bus bundle between the SPI transfer controller and its environment: start
// request, word data, mode pins, baud-generator strobes, serial lines and status.
interface spi_shift_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              send_data;
    logic [DATA_W-1:0] data_mosi;
    logic              lsbfe;
    logic              cpol;
    logic              cpha;
    logic [1:0]        spi_mode;
    logic              spiswai;
    logic              flags_low;
    logic              flag_low;
    logic              flags_high;
    logic              flag_high;
    logic              miso;
    logic              ss;
    logic              tip;
    logic              mosi;
    logic [DATA_W-1:0] data_miso;
    logic              receive_data;
    logic [1:0]        state_dbg;

    // Start handshake: send_data is a one-cycle request, accepted only in IDLE
    // while enabled; acceptance is visible as ss falling one cycle later.
    // Completion is the one-cycle receive_data pulse with data_miso valid.
    modport slave (
        input  send_data, data_mosi, lsbfe, cpol, cpha, spi_mode, spiswai,
        input  flags_low, flag_low, flags_high, flag_high, miso,
        output ss, tip, mosi, data_miso, receive_data, state_dbg
    );

    modport master (
        output send_data, data_mosi, lsbfe, cpol, cpha, spi_mode, spiswai,
        output flags_low, flag_low, flags_high, flag_high, miso,
        input  ss, tip, mosi, data_miso, receive_data, state_dbg
    );
endinterface

// File: rtl/spi_shift_ctrl.sv
// SPI master transfer controller: frames one word with ss, shifts mosi out and
// miso in on the baud generator's strobes, and pulses receive_data at the end.
module spi_shift_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input logic              PCLK,
    input logic              PRESETn,
    spi_shift_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    state_t            state, state_n;
    logic [DATA_W-1:0] tx_sr, tx_n;
    logic [DATA_W-1:0] rx_sr, rx_n;
    logic [CNT_W-1:0]  bit_cnt, cnt_n;
    logic              lsb_q, lsb_n;
    logic              ss_q, ss_n;
    logic              tip_q, tip_n;
    logic              mosi_q, mosi_n;
    logic [DATA_W-1:0] miso_q, miso_n;
    logic              rcv_q, rcv_n;

    logic en;
    logic sample_stb;
    logic shift_stb;

    assign en         = (bus.spi_mode == 2'b00) || ((bus.spi_mode == 2'b01) && !bus.spiswai);
    assign sample_stb = (bus.cpol == bus.cpha) ? bus.flags_low : bus.flags_high;
    assign shift_stb  = (bus.cpol == bus.cpha) ? bus.flag_low  : bus.flag_high;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            lsb_q   <= 1'b0;
            ss_q    <= 1'b1;
            tip_q   <= 1'b0;
            mosi_q  <= 1'b0;
            miso_q  <= '0;
            rcv_q   <= 1'b0;
        end else begin
            state   <= state_n;
            tx_sr   <= tx_n;
            rx_sr   <= rx_n;
            bit_cnt <= cnt_n;
            lsb_q   <= lsb_n;
            ss_q    <= ss_n;
            tip_q   <= tip_n;
            mosi_q  <= mosi_n;
            miso_q  <= miso_n;
            rcv_q   <= rcv_n;
        end
    end

    always_comb begin
        state_n = state;
        tx_n    = tx_sr;
        rx_n    = rx_sr;
        cnt_n   = bit_cnt;
        lsb_n   = lsb_q;
        ss_n    = ss_q;
        tip_n   = tip_q;
        mosi_n  = mosi_q;
        miso_n  = miso_q;
        rcv_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.send_data && en) begin
                    tx_n    = bus.data_mosi;
                    lsb_n   = bus.lsbfe;
                    cnt_n   = '0;
                    rx_n    = '0;
                    ss_n    = 1'b0;
                    tip_n   = 1'b1;
                    mosi_n  = bus.lsbfe ? bus.data_mosi[0] : bus.data_mosi[DATA_W-1];
                    state_n = XFER;
                end
            end
            XFER: begin
                if (!en) begin
                    ss_n    = 1'b1;
                    tip_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    // Sample is applied first so a coincident shift sees the new count.
                    if (sample_stb) begin
                        rx_n  = lsb_q ? {bus.miso, rx_sr[DATA_W-1:1]}
                                      : {rx_sr[DATA_W-2:0], bus.miso};
                        cnt_n = bit_cnt + CNT_W'(1);
                    end
                    if (shift_stb) begin
                        if (cnt_n < LAST_CNT) begin
                            tx_n   = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
                            mosi_n = lsb_q ? tx_n[0] : tx_n[DATA_W-1];
                        end else begin
                            miso_n  = rx_n;
                            rcv_n   = 1'b1;
                            ss_n    = 1'b1;
                            tip_n   = 1'b0;
                            state_n = GAP;
                        end
                    end
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.ss           = ss_q;
    assign bus.tip          = tip_q;
    assign bus.mosi         = mosi_q;
    assign bus.data_miso    = miso_q;
    assign bus.receive_data = rcv_q;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_spi_shift_ctrl.sv
// Bench for spi_shift_ctrl: emulates the baud generator strobes, checks serial
// bit order and received words against a bit-level model, plus corner sequences.
module tb_spi_shift_ctrl;
    localparam int W = 8;

    logic pclk = 1'b0;
    logic presetn;
    always #5 pclk = ~pclk;

    spi_shift_ctrl_if #(.DATA_W(W)) bus ();

    spi_shift_ctrl #(.DATA_W(W), .CNT_W(4)) dut (
        .PCLK    (pclk),
        .PRESETn (presetn),
        .bus     (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    int rcv_seen = 0;
    int rcv_expected = 0;
    logic [W-1:0] exp_q[$];
    logic sel_low = 1'b1;

    // Serial sequences are in transmission order: first bit on the wire is bit W-1.
    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] miso_seq;
        logic         lsb;
        logic         cpol;
        logic         cpha;
        logic [W-1:0] exp_mosi_seq;
        logic [W-1:0] exp_rx;
    } vec_t;
    vec_t vecs[5];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Wire order of a word as a transmitter sends it.
    function automatic logic [W-1:0] wire_order(logic [W-1:0] word, logic lsb);
        logic [W-1:0] seq = '0;
        for (int i = 0; i < W; i++) seq[W-1-i] = lsb ? word[i] : word[W-1-i];
        return seq;
    endfunction

    // Word assembled by a receiver from bits arriving in wire order.
    function automatic logic [W-1:0] assemble(logic [W-1:0] seq, logic lsb);
        logic [W-1:0] word = '0;
        for (int i = 0; i < W; i++) begin
            if (lsb) word[i] = seq[W-1-i];
            else     word[W-1-i] = seq[W-1-i];
        end
        return word;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_flags(logic s, logic sh, bit noise);
        if (sel_low) begin
            bus.flags_low  = s;
            bus.flag_low   = sh;
            bus.flags_high = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.flag_high  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
            bus.flags_high = s;
            bus.flag_high  = sh;
            bus.flags_low  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.flag_low   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic start_xfer(logic [W-1:0] data, logic lsb, logic cpol, logic cpha,
                              bit push, logic [W-1:0] exp_rx);
        bus.cpol      = cpol;
        bus.cpha      = cpha;
        sel_low       = (cpol == cpha);
        bus.data_mosi = data;
        bus.lsbfe     = lsb;
        bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
        bus.data_mosi = W'($urandom);
        bus.lsbfe     = 1'($urandom_range(0, 1));
        check("start_ss", bus.ss, 1'b0);
        check("start_tip", bus.tip, 1'b1);
        if (push) begin
            exp_q.push_back(exp_rx);
            rcv_expected++;
        end
    endtask

    // One bit period of 2*D PCLK with D=2: idle, sample, idle, shift.
    task automatic do_bit(logic exp_bit, logic miso_bit, bit noise, bit poke);
        check("mosi_bit", bus.mosi, exp_bit);
        bus.send_data = poke;
        drive_flags(1'b0, 1'b0, noise);
        tick();
        bus.send_data = 1'b0;
        bus.miso = miso_bit;
        drive_flags(1'b1, 1'b0, noise);
        tick();
        bus.miso = ~miso_bit;
        drive_flags(1'b0, 1'b0, noise);
        tick();
        drive_flags(1'b0, 1'b1, noise);
        tick();
        drive_flags(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_bits(logic [W-1:0] mosi_seq, logic [W-1:0] miso_seq, int nbits,
                            bit noise, int poke_bit);
        for (int i = 0; i < nbits; i++)
            do_bit(mosi_seq[W-1-i], miso_seq[W-1-i], noise, i == poke_bit);
    endtask

    task automatic finish_checks(logic [W-1:0] exp_rx);
        check("done_rcv", bus.receive_data, 1'b1);
        check("done_data_miso", bus.data_miso, exp_rx);
        check("done_ss", bus.ss, 1'b1);
        check("done_tip", bus.tip, 1'b0);
    endtask

    // Scoreboard: every receive_data pulse consumes one expected word.
    always @(negedge pclk) begin
        if (presetn === 1'b1 && bus.receive_data === 1'b1) begin
            rcv_seen++;
            if (exp_q.size() == 0) check("rcv_unexpected", bus.receive_data, 1'b0);
            else check("sb_data_miso", bus.data_miso, exp_q.pop_front());
        end
    end

    initial begin
        int hi;
        logic [W-1:0] d, ms, seq;
        logic l, cp, ch;

        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C};
        vecs[1] = '{8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h80, 8'hFF};
        vecs[2] = '{8'hC3, 8'h5A, 1'b1, 1'b1, 1'b1, 8'hC3, 8'h5A};
        vecs[3] = '{8'h96, 8'h81, 1'b0, 1'b1, 1'b0, 8'h96, 8'h81};
        vecs[4] = '{8'h0F, 8'h0F, 1'b1, 1'b0, 1'b0, 8'hF0, 8'hF0};

        presetn = 1'b0;
        bus.send_data = 0; bus.data_mosi = '0; bus.lsbfe = 0; bus.cpol = 0; bus.cpha = 0;
        bus.spi_mode = 2'b00; bus.spiswai = 0; bus.miso = 0;
        bus.flags_low = 0; bus.flag_low = 0; bus.flags_high = 0; bus.flag_high = 0;
        #12;
        check("rst_ss", bus.ss, 1'b1);
        check("rst_tip", bus.tip, 1'b0);
        check("rst_mosi", bus.mosi, 1'b0);
        check("rst_data_miso", bus.data_miso, '0);
        check("rst_rcv", bus.receive_data, 1'b0);
        #5 presetn = 1'b1;
        tick();

        // Directed table over all four cpol/cpha combinations.
        for (int v = 0; v < 5; v++) begin
            start_xfer(vecs[v].data, vecs[v].lsb, vecs[v].cpol, vecs[v].cpha, 1, vecs[v].exp_rx);
            run_bits(vecs[v].exp_mosi_seq, vecs[v].miso_seq, W, 0, -1);
            finish_checks(vecs[v].exp_rx);
            tick();
            check("gap_rcv_low", bus.receive_data, 1'b0);
            check("gap_ss", bus.ss, 1'b1);
            tick();
        end

        // Asynchronous reset three bits into a transfer, then a clean transfer.
        start_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 0, '0);
        run_bits(8'hA5, 8'h3C, 3, 0, -1);
        #2 presetn = 1'b0;
        #1;
        check("midrst_ss", bus.ss, 1'b1);
        check("midrst_tip", bus.tip, 1'b0);
        check("midrst_mosi", bus.mosi, 1'b0);
        check("midrst_data_miso", bus.data_miso, '0);
        check("midrst_rcv", bus.receive_data, 1'b0);
        #3 presetn = 1'b1;
        tick();
        start_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'h3C);
        run_bits(8'hA5, 8'h3C, W, 0, -1);
        finish_checks(8'h3C);
        tick(); tick();

        // Wait mode, then stop-in-wait raised after four bits aborts the word.
        bus.spi_mode = 2'b01;
        start_xfer(8'h55, 1'b0, 1'b0, 1'b0, 0, '0);
        run_bits(8'h55, 8'hC9, 4, 0, -1);
        bus.spiswai = 1'b1;
        tick();
        check("abort_ss", bus.ss, 1'b1);
        check("abort_tip", bus.tip, 1'b0);
        check("abort_rcv", bus.receive_data, 1'b0);
        tick();
        check("abort_data_miso", bus.data_miso, 8'h3C);
        bus.spiswai = 1'b0;
        bus.spi_mode = 2'b00;

        // Stop mode ignores the start request.
        bus.spi_mode = 2'b10;
        bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
        check("stop_ss", bus.ss, 1'b1);
        check("stop_tip", bus.tip, 1'b0);
        bus.spi_mode = 2'b00;
        tick();

        // send_data pulsed during XFER and during GAP is dropped.
        start_xfer(8'h6E, 1'b1, 1'b1, 1'b0, 1, 8'hB2);
        run_bits(wire_order(8'h6E, 1'b1), wire_order(8'hB2, 1'b1), W, 0, 2);
        finish_checks(8'hB2);
        bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
        check("gap_poke_ss", bus.ss, 1'b1);
        tick();
        check("gap_poke_ss2", bus.ss, 1'b1);
        check("gap_poke_tip", bus.tip, 1'b0);

        // Back-to-back: restart the cycle after GAP gives a 2-cycle ss-high window.
        start_xfer(8'h3A, 1'b0, 1'b0, 1'b0, 1, 8'hE4);
        run_bits(8'h3A, 8'hE4, W, 0, -1);
        finish_checks(8'hE4);
        hi = 0;
        if (bus.ss) hi++;
        tick();
        if (bus.ss) hi++;
        start_xfer(8'hC5, 1'b1, 1'b0, 1'b0, 1, 8'h17);
        check("b2b_ss_high_cycles", 32'(hi), 32'd2);
        run_bits(wire_order(8'hC5, 1'b1), wire_order(8'h17, 1'b1), W, 0, -1);
        finish_checks(8'h17);
        tick(); tick();

        // Randomised transfers with noise on the unselected strobe pair.
        for (int r = 0; r < 20; r++) begin
            d  = W'($urandom);
            ms = W'($urandom);
            l  = 1'($urandom_range(0, 1));
            cp = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            seq = wire_order(d, l);
            start_xfer(d, l, cp, ch, 1, assemble(ms, l));
            run_bits(seq, ms, W, 1, -1);
            finish_checks(assemble(ms, l));
            tick();
            tick();
        end

        repeat (3) tick();
        check("rcv_pulse_count", 32'(rcv_seen), 32'(rcv_expected));
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/spi_shift_ctrl.md
Name: spi_shift_ctrl

Overview:
- Transfer controller and shift register for the SPI master. It sits directly downstream of the baud-rate generator and consumes that block's edge-warning flags.
- It drives slave select (ss) back to the generator. This ss doubles as the generator's enable.
- Serialises one DATA_W-bit word onto mosi while deserialising miso into a receive register.
- Reports completion with a single-cycle receive_data pulse.

Parameters:
- DATA_W, 8, transfer word width in bits.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- PCLK  input  1  system clock; all logic on the rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- send_data  input  1  single-cycle start request.
- data_mosi  input  DATA_W  word to transmit; sampled only on an accepted start.
- lsbfe  input  1  1 = LSB first, 0 = MSB first; sampled on accepted start.
- cpol  input  1  clock polarity.
- cpha  input  1  clock phase.
- spi_mode  input  2  00 = run, 01 = wait, others = stop.
- spiswai  input  1  stop-in-wait.
- flags_low  input  1  pre-edge strobe, low-phase modes.
- flag_low  input  1  post-edge strobe, low-phase modes.
- flags_high  input  1  pre-edge strobe, high-phase modes.
- flag_high  input  1  post-edge strobe, high-phase modes.
- miso  input  1  serial data from slave.
- ss  output  1  active-low slave select; also the generator enable.
- tip  output  1  transfer in progress.
- mosi  output  1  serial data to slave.
- data_miso  output  DATA_W  last completed received word.
- receive_data  output  1  one-cycle completion pulse.

Behaviour:
- Reset (PRESETn low, asynchronous): ss=1, tip=0, mosi=0, data_miso=0, receive_data=0, bit_cnt=0, state=IDLE, tx/rx shift registers=0.
- Enable: en = (spi_mode==00) | (spi_mode==01 & !spiswai).
- Strobe selection (combinational):
  - cpol==cpha: sample_stb=flags_low, shift_stb=flag_low.
  - otherwise: sample_stb=flags_high, shift_stb=flag_high.
- States: IDLE, XFER, GAP.
- IDLE:
  - send_data & en: load tx_sr=data_mosi; latch lsbfe; bit_cnt=0; rx_sr=0; ss<=0; tip<=1; mosi<=first bit (lsbfe ? data_mosi[0] : data_mosi[DATA_W-1]); go XFER.
  - send_data & !en: ignored.
- XFER, on sample_stb:
  - rx_sr captures miso.
  - lsbfe=1: shift right, miso enters bit DATA_W-1.
  - lsbfe=0: shift left, miso enters bit 0.
  - bit_cnt += 1.
- XFER, on shift_stb with bit_cnt<DATA_W: tx_sr shifts in the latched direction; mosi <= next bit.
- XFER, on shift_stb with bit_cnt==DATA_W: data_miso<=rx_sr; receive_data=1 for exactly one cycle; ss<=1; tip<=0; go GAP.
- Simultaneous sample_stb and shift_stb (not produced by the generator, but defined): apply the sample first; the shift then uses the incremented bit_cnt.
- send_data during XFER or GAP is ignored and not queued.
- Abort: en low in XFER → next cycle ss=1, tip=0, state=IDLE. data_miso is unchanged and no receive_data pulse is issued. bit_cnt is cleared.
- GAP: exactly one cycle with ss=1, then IDLE. This guarantees a minimum ss-high time of 2 PCLK between words.
- mosi holds its last driven value outside XFER. data_miso holds until the next completed transfer.
- Mode pins (cpol, cpha) changing mid-transfer: takes effect immediately on strobe selection. Not a supported use, and not checked.
- Timing: with divisor D, each bit spans 2·D PCLK. ss is low for about DATA_W·2·D cycles.

Test Plan:
- Mode 0, D=2, lsbfe=0, data_mosi=0xA5, miso driven from pattern 0x3C MSB-first → mosi bits 1,0,1,0,0,1,0,1. data_miso=0x3C with a single receive_data pulse; ss high afterwards; tip low.
- Mode 1 (cpha=1, cpol=0) using flags_high/flag_high, lsbfe=1, data_mosi=0x01, miso=0xFF → mosi first bit 1, then seven 0s. data_miso=0xFF.
- Reset asserted mid-XFER after 3 bits → immediately ss=1, tip=0, mosi=0, data_miso=0, receive_data=0. The next send_data starts a clean transfer.
- spi_mode=01 with spiswai raised after 4 bits → ss=1 the next cycle, no receive_data, data_miso retains the previous value (e.g. 0x3C).
- send_data pulsed during XFER and during GAP → ignored; exactly one receive_data per accepted start. send_data with spi_mode=10 → ss stays 1.
- Back-to-back: send_data asserted the cycle after GAP → a second transfer starts, with ss high for exactly 2 cycles between words.
